conv3x3_stream: RTL and testbench
=================================

Name: conv3x3_stream

Overview:
Downstream consumer of the row-delay line buffers in the pixel processing path.
- Accepts three column-aligned row taps per pixel: current row, row-1 and row-2.
- Forms a sliding 3x3 window and applies a signed 3x3 kernel as a MAC.
- Emits one clamped 8-bit pixel per valid window over a ready/valid stream.
- Drives in_ready back to the line-buffer enable so the whole row pipeline stalls together.

Parameters:
- IMAGE_SIZE, 32, pixels per row and rows per frame (square frame).
- PTR_WIDTH, $clog2(IMAGE_SIZE), width of the row and column counters.
- SHIFT, 0, arithmetic right shift applied to the sum before clamping (0..12).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  row taps valid.
- in_ready  out  1  block accepts a pixel; upstream uses it as the line-buffer shift enable.
- in_sof  in  1  qualifies the accepted pixel as frame (0,0).
- row0_px  in  8  current-row pixel, unsigned.
- row1_px  in  8  pixel one row above.
- row2_px  in  8  pixel two rows above.
- coef_flat  in  72  nine signed 8-bit coefs; k[0] at [7:0]; row-major, top-left first.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts.
- out_px  out  8  filtered pixel, clamped to 0..255.
- out_last  out  1  last output pixel of the frame.

Behaviour:
- Reset: in_ready=0 while rstn low, 1 from the first clk after release. out_valid=0, out_px=0, out_last=0. All counters, window regs, pipeline valids and the coef shadow are 0.
- Accept: a pixel is accepted when in_valid && in_ready.
- Stall: stall = out_valid && !out_ready; in_ready = !stall.
  - While stalled, every pipeline register holds, including the window, counters and valids.
- Counters: col counts 0..IMAGE_SIZE-1, and row advances when col wraps.
  - row wraps IMAGE_SIZE-1 -> 0 at the last pixel of the frame.
  - An accepted pixel with in_sof forces that pixel to (row 0, col 0) even mid-frame (resync).
- Coef capture: coef_flat is copied into a shadow register on the accepted sof pixel. Coef changes mid-frame have no effect.
- Window: 3 columns x 3 rows of shift registers, shifting on accept.
  - Newest column is {row2_px, row1_px, row0_px}; window top row = row2 taps.
- win_valid is set for an accepted pixel with row>=2 && col>=2; windows straddling a row wrap are discarded.
  - Outputs per frame: (IMAGE_SIZE-2)^2, i.e. 900 at 32.
- Pipeline (all registers advance when !stall):
  - S1: window plus win_valid; out_last tag = (row==IMAGE_SIZE-1 && col==IMAGE_SIZE-1).
  - S2: nine products, zero-extended u8 x s8 -> s17.
  - S3: adder tree, signed 21-bit sum with no overflow possible.
  - S4: arithmetic >>> SHIFT, clamp <0 -> 0 and >255 -> 255; registered onto out_px/out_valid/out_last.
- Latency: accepted pixel completing a window -> out_valid 4 cycles later, absent stall. Throughput is 1 pixel/clk.
- out_px and out_last hold stable while out_valid && !out_ready.
- Invalid bubbles propagate with valid=0; out_px is don't-care when out_valid=0.
- Simultaneous accept and output handshake in one cycle is legal and causes no loss.
- Reset mid-frame: all in-flight results are dropped, and the next frame requires in_sof.

Optional Feature:
- Macro: CONV3X3_ABS_EN.
- Defined: S4 takes |sum>>>SHIFT| before the upper clamp, for edge-detect kernels; negative sums map to their magnitude, and only the upper clamp at 255 applies.
- Undefined: negative sums clamp to 0.

Decomposition:
- Shared package pixel_proc_pkg:
  - PIX_W=8, COEF_W=8, PROD_W=17, SUM_W=21.
  - A 3x3 window typedef (array of pixel words).
  - A coef unpack helper constant/function for coef_flat indexing.
- One natural sub-module, conv3x3_mac: S2-S4 datapath with a stall-enable input, separated from the window/counter/handshake control in conv3x3_stream.

Test Plan:
1. Identity kernel, SHIFT=0, 32x32 ramp p=(r*32+c)&255 with aligned taps -> 900 outputs, out_px = p[r-1][c-1] in raster order; out_last only on the 900th output.
2. All-ones kernel, SHIFT=3, constant 200 frame -> every out_px = 1800>>3 = 225; first out_valid 4 cycles after accepting pixel (2,2).
3. Center=-1, all other coefs 0, frame of 50 -> out_px = 0; with CONV3X3_ABS_EN -> 50. All-ones, SHIFT=0, frame of 255 -> 255 (clamped).
4. Random out_ready at 30% duty, ramp frame -> identical output sequence to test 1; in_ready low exactly when out_valid && !out_ready; no duplicate or dropped pixels.
5. in_sof reasserted at pixel (10,5) -> counters restart; the next frame again yields exactly 900 outputs. coef_flat changed mid-frame has no effect until the next sof.
6. rstn pulsed low mid-frame while stalled -> out_valid, out_px and out_last all 0 immediately (async); no output until a new sof frame fills 2 rows + 3 pixels.

Source files
------------

// File: rtl/pixel_proc_pkg.sv
// Shared types and constants for the pixel processing path.
//
// Contents:
//   PIX_W / COEF_W / PROD_W / SUM_W : datapath widths (u8 pixels, s8 coefs,
//                                     s17 products, s21 nine-term sums)
//   win_t       : 3x3 pixel window, indexed [row][col], row 0 = top (oldest row),
//                 col 0 = left (oldest column)
//   coef_arr_t  : nine signed coefficients, index 0 = top-left, row-major
//   coef_unpack : splits the flat 72-bit coefficient bus into coef_arr_t
package pixel_proc_pkg;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 8;
    localparam int PROD_W = 17;
    localparam int SUM_W  = 21;
    localparam int TAPS   = 9;

    typedef logic [PIX_W-1:0]         pix_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef pix_t  [2:0][2:0]         win_t;
    typedef coef_t [TAPS-1:0]         coef_arr_t;

    // k[0] sits in the least significant byte of the flat bus.
    function automatic coef_arr_t coef_unpack(input logic [TAPS*COEF_W-1:0] flat);
        coef_arr_t k;
        for (int i = 0; i < TAPS; i++) begin
            k[i] = coef_t'(flat[i*COEF_W +: COEF_W]);
        end
        return k;
    endfunction

endpackage

// File: rtl/conv3x3_mac.sv
// S2..S4 arithmetic of the 3x3 convolution: nine u8 x s8 products, the
// nine-term sum, then arithmetic shift and clamp to an 8-bit pixel.
// Every register advances only when en is high, so the whole datapath freezes
// together with the window/counter control while the output is back-pressured.
//
// Optional build macro CONV3X3_ABS_EN: take the magnitude of the shifted sum
// before clamping (edge-detect kernels); otherwise negative sums clamp to 0.
//
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   en           advance enable (low while the output is stalled)
//   vld_p1       S1 window valid
//   last_p1      S1 last-pixel-of-frame tag
//   win_p1       S1 3x3 window
//   coef         captured kernel coefficients
//   out_valid    S4 output valid
//   out_px       S4 clamped pixel
//   out_last     S4 last-pixel-of-frame tag
module conv3x3_mac
    import pixel_proc_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             vld_p1,
    input  logic             last_p1,
    input  win_t             win_p1,
    input  coef_arr_t        coef,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_px,
    output logic             out_last
);

    localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'(255);

    logic signed [PROD_W-1:0] prod_p2 [TAPS];
    logic                     vld_p2;
    logic                     last_p2;
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [SUM_W-1:0]  sum_p3;
    logic                     vld_p3;
    logic                     last_p3;

    // Pixel is zero-extended so it stays non-negative in the signed product.
    function automatic logic signed [PROD_W-1:0] mul_px(input pix_t p, input coef_t k);
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = {{(PROD_W-PIX_W){1'b0}}, p};
        b = {{(PROD_W-COEF_W){k[COEF_W-1]}}, k};
        return a * b;
    endfunction

    function automatic logic [PIX_W-1:0] shift_clamp(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] v;
        v = s >>> SHIFT;
`ifdef CONV3X3_ABS_EN
        if (v[SUM_W-1]) begin
            v = -v;
        end
`endif
        if (v[SUM_W-1]) begin
            return '0;
        end else if (v > PIX_MAX) begin
            return '1;
        end else begin
            return v[PIX_W-1:0];
        end
    endfunction

    // S1 -> S2: products
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TAPS; i++) begin
                prod_p2[i] <= '0;
            end
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else if (en) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    prod_p2[r*3+c] <= mul_px(win_p1[r][c], coef[r*3+c]);
                end
            end
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
        end
    end

    // Nine s17 terms cannot overflow s21, so plain sign-extended accumulation is exact.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum_c = sum_c + {{(SUM_W-PROD_W){prod_p2[i][PROD_W-1]}}, prod_p2[i]};
        end
    end

    // S2 -> S3: sum
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_p3  <= '0;
            vld_p3  <= 1'b0;
            last_p3 <= 1'b0;
        end else if (en) begin
            sum_p3  <= sum_c;
            vld_p3  <= vld_p2;
            last_p3 <= last_p2;
        end
    end

    // S3 -> S4: shift, clamp, output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_px    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (en) begin
            out_px    <= shift_clamp(sum_p3);
            out_valid <= vld_p3;
            out_last  <= last_p3;
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution fed by three column-aligned row taps from the
// upstream line buffers. Tracks the pixel position, builds the sliding window,
// captures the kernel at start of frame and hands windows to conv3x3_mac.
// in_ready doubles as the line-buffer shift enable, so back-pressure on the
// output stalls the whole row pipeline in lockstep.
//
// Optional build macro CONV3X3_ABS_EN (see conv3x3_mac): magnitude output.
//
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready low during reset)
//   in_sof                accepted pixel is frame position (0,0)
//   row0_px/row1_px/row2_px  current row, row-1, row-2 taps (unsigned)
//   coef_flat             nine signed 8-bit coefs, k[0] in [7:0], row-major
//   out_valid / out_ready output handshake
//   out_px                filtered pixel clamped to 0..255
//   out_last              last output pixel of the frame
module conv3x3_stream
    import pixel_proc_pkg::*;
#(
    parameter int IMAGE_SIZE = 32,
    parameter int PTR_WIDTH  = $clog2(IMAGE_SIZE),
    parameter int SHIFT      = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sof,
    input  logic [PIX_W-1:0]       row0_px,
    input  logic [PIX_W-1:0]       row1_px,
    input  logic [PIX_W-1:0]       row2_px,
    input  logic [TAPS*COEF_W-1:0] coef_flat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIX_W-1:0]       out_px,
    output logic                   out_last
);

    localparam logic [PTR_WIDTH-1:0] LAST_IDX   = PTR_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [PTR_WIDTH-1:0] FIRST_FULL = PTR_WIDTH'(2);
    localparam logic [PTR_WIDTH-1:0] ONE        = PTR_WIDTH'(1);

    logic                 run;
    logic                 stall;
    logic                 accept;
    logic                 synced;
    logic                 win_ok;
    logic [PTR_WIDTH-1:0] col;
    logic [PTR_WIDTH-1:0] row;
    logic [PTR_WIDTH-1:0] pos_col;
    logic [PTR_WIDTH-1:0] pos_row;
    coef_arr_t            coef_sh;
    win_t                 win_p1;
    logic                 vld_p1;
    logic                 last_p1;

    assign stall    = out_valid && !out_ready;
    assign in_ready = run && !stall;
    assign accept   = in_valid && in_ready;

    // Position of the pixel being offered; sof forces (0,0) even mid-frame.
    assign pos_col = in_sof ? '0 : col;
    assign pos_row = in_sof ? '0 : row;

    // Windows only count once a sof has been seen since reset, and only when
    // the window lies fully inside the current row band (no wrap straddle).
    assign win_ok = accept && (synced || in_sof)
                    && (pos_row >= FIRST_FULL) && (pos_col >= FIRST_FULL);

    // in_ready stays low until the first clock after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col    <= '0;
            row    <= '0;
            synced <= 1'b0;
        end else if (accept) begin
            if (in_sof) begin
                synced <= 1'b1;
            end
            if (pos_col == LAST_IDX) begin
                col <= '0;
                row <= (pos_row == LAST_IDX) ? '0 : pos_row + ONE;
            end else begin
                col <= pos_col + ONE;
                row <= pos_row;
            end
        end
    end

    // Kernel is frozen for the whole frame; mid-frame coef_flat changes wait for the next sof.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            coef_sh <= '0;
        end else if (accept && in_sof) begin
            coef_sh <= coef_unpack(coef_flat);
        end
    end

    // Input -> S1: window shift and window tags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_p1 <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_p1[r][0] <= win_p1[r][1];
                win_p1[r][1] <= win_p1[r][2];
            end
            win_p1[0][2] <= row2_px;
            win_p1[1][2] <= row1_px;
            win_p1[2][2] <= row0_px;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1  <= win_ok;
            last_p1 <= win_ok && (pos_row == LAST_IDX) && (pos_col == LAST_IDX);
        end
    end

    conv3x3_mac #(
        .SHIFT (SHIFT)
    ) u_mac (
        .clk       (clk),
        .rstn      (rstn),
        .en        (!stall),
        .vld_p1    (vld_p1),
        .last_p1   (last_p1),
        .win_p1    (win_p1),
        .coef      (coef_sh),
        .out_valid (out_valid),
        .out_px    (out_px),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream. Two instances share all inputs: dut
// (SHIFT=0) and dut3 (SHIFT=3). Frames are sent pixel by pixel with aligned
// row taps; expected outputs are queued per accepted window-completing pixel.
module tb_conv3x3_stream;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  row0_px;
    logic [7:0]  row1_px;
    logic [7:0]  row2_px;
    logic [71:0] coef_flat;
    logic        out_ready;
    logic        in_ready, in_ready3;
    logic        out_valid, out_valid3;
    logic [7:0]  out_px, out_px3;
    logic        out_last, out_last3;

    always #5 clk = ~clk;

    conv3x3_stream #(.IMAGE_SIZE(32), .SHIFT(0)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .row0_px(row0_px), .row1_px(row1_px), .row2_px(row2_px),
        .coef_flat(coef_flat), .out_valid(out_valid), .out_ready(out_ready),
        .out_px(out_px), .out_last(out_last)
    );

    conv3x3_stream #(.IMAGE_SIZE(32), .SHIFT(3)) dut3 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready3),
        .in_sof(in_sof), .row0_px(row0_px), .row1_px(row1_px), .row2_px(row2_px),
        .coef_flat(coef_flat), .out_valid(out_valid3), .out_ready(out_ready),
        .out_px(out_px3), .out_last(out_last3)
    );

    localparam logic [71:0] K_ID   = 72'h000000000100000000;
    localparam logic [71:0] K_ONES = 72'h010101010101010101;
    localparam logic [71:0] K_NEG  = 72'h00000000FF00000000;

`ifdef CONV3X3_ABS_EN
    localparam int NEG_E  = 50;
    localparam int NEG_E3 = 7;
`else
    localparam int NEG_E  = 0;
    localparam int NEG_E3 = 0;
`endif

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         outs = 0;
    int         lasts = 0;
    int         rdy_pct = 100;
    int         acc_cyc = 0;
    int         first_vld_cyc = -1;
    logic       push_en = 1'b1;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_px = 8'd0;
    logic       prev_last = 1'b0;
    logic [8:0] exp_q[$];
    logic [7:0] exp3_q[$];
    logic       idle_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // kind 0: ramp (r*32+c)&255; otherwise constant val. Rows above the frame read 0.
    function automatic logic [7:0] pix(input int kind, input int val, input int r, input int c);
        if (r < 0) return 8'd0;
        if (kind == 0) return 8'((r * 32 + c) & 255);
        return 8'(val);
    endfunction

    task automatic cycle(input logic v, input logic sof, input logic [7:0] r0,
                         input logic [7:0] r1, input logic [7:0] r2, output logic acc);
        logic [8:0] e;
        logic [7:0] e3;
        @(negedge clk);
        cyc++;
        in_valid  = v;
        in_sof    = sof;
        row0_px   = r0;
        row1_px   = r1;
        row2_px   = r2;
        out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
        #1;
        chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
        chk("in_ready3_rule", in_ready3, !(out_valid3 && !out_ready));
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_px", out_px, prev_px);
            chk("hold_last", out_last, prev_last);
        end
        if (out_valid && out_ready) begin
            outs++;
            if (out_last) lasts++;
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            chk("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                e3 = exp3_q.pop_front();
                chk("out_px", out_px, e[7:0]);
                chk("out_last", out_last, e[8]);
                chk("dut3_valid", out_valid3, 1);
                chk("dut3_px", out_px3, e3);
                chk("dut3_last", out_last3, e[8]);
            end
        end
        acc        = v && in_ready;
        prev_stall = out_valid && !out_ready;
        prev_px    = out_px;
        prev_last  = out_last;
    endtask

    task automatic send_px(input int kind, input int val, input int r, input int c,
                           input logic sof, input int e, input int e3);
        logic       acc;
        int         tries;
        logic [7:0] px;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            cycle(1'b1, sof, pix(kind, val, r, c), pix(kind, val, r - 1, c),
                  pix(kind, val, r - 2, c), acc);
            tries++;
        end
        chk("accept_in_budget", acc, 1);
        if (acc) begin
            if (r == 2 && c == 2) acc_cyc = cyc;
            if (push_en && r >= 2 && c >= 2) begin
                if (kind == 0) begin
                    px = pix(0, 0, r - 1, c - 1);
                    exp_q.push_back({(r == 31 && c == 31), px});
                    exp3_q.push_back(px >> 3);
                end else begin
                    exp_q.push_back({(r == 31 && c == 31), 8'(e)});
                    exp3_q.push_back(8'(e3));
                end
            end
        end
    endtask

    // Raster-order pixels from (rs,cs) up to but excluding (re,ce).
    task automatic send_seq(input int kind, input int val, input int e, input int e3,
                            input logic sof_first, input int rs, input int cs,
                            input int re, input int ce);
        int   r;
        int   c;
        logic first;
        r = rs;
        c = cs;
        first = 1'b1;
        while (!(r == re && c == ce)) begin
            send_px(kind, val, r, c, sof_first && first, e, e3);
            first = 1'b0;
            c++;
            if (c == 32) begin
                c = 0;
                r++;
            end
        end
    endtask

    task automatic drain();
        logic a;
        int   n;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, a);
            n++;
        end
        repeat (10) cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, a);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        row0_px   = 8'd0;
        row1_px   = 8'd0;
        row2_px   = 8'd0;
        out_ready = 1'b1;
        coef_flat = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_px", out_px, 0);
        chk("rst_out_last", out_last, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("ready_before_clk", in_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_clk", in_ready, 1);

        // 1: identity kernel, ramp frame
        coef_flat = K_ID;
        outs = 0;
        lasts = 0;
        send_seq(0, 0, 0, 0, 1'b1, 0, 0, 32, 0);
        drain();
        chk("t1_outputs", outs, 900);
        chk("t1_lasts", lasts, 1);

        // 2: all-ones, constant 200 -> 1800 (clamped 255 at SHIFT 0, 225 at SHIFT 3)
        coef_flat = K_ONES;
        outs = 0;
        first_vld_cyc = -1;
        send_seq(1, 200, 255, 225, 1'b1, 0, 0, 32, 0);
        drain();
        chk("t2_latency", first_vld_cyc - acc_cyc, 4);
        chk("t2_outputs", outs, 900);

        // 3a: negative centre tap on constant 50
        coef_flat = K_NEG;
        outs = 0;
        send_seq(1, 50, NEG_E, NEG_E3, 1'b1, 0, 0, 32, 0);
        drain();
        chk("t3a_outputs", outs, 900);

        // 3b: all-ones on constant 255 -> 2295, clamps to 255 at both shifts
        coef_flat = K_ONES;
        outs = 0;
        send_seq(1, 255, 255, 255, 1'b1, 0, 0, 32, 0);
        drain();
        chk("t3b_outputs", outs, 900);

        // 4: ramp frame with out_ready at 30%
        coef_flat = K_ID;
        rdy_pct = 30;
        outs = 0;
        lasts = 0;
        send_seq(0, 0, 0, 0, 1'b1, 0, 0, 32, 0);
        drain();
        rdy_pct = 100;
        chk("t4_outputs", outs, 900);
        chk("t4_lasts", lasts, 1);

        // 5: resync at (10,5), coef change mid-frame ignored, then takes effect
        coef_flat = K_ID;
        outs = 0;
        lasts = 0;
        send_seq(0, 0, 0, 0, 1'b1, 0, 0, 10, 5);
        send_seq(0, 0, 0, 0, 1'b1, 0, 0, 16, 0);
        coef_flat = K_ONES;
        send_seq(0, 0, 0, 0, 1'b0, 16, 0, 32, 0);
        drain();
        chk("t5_outputs", outs, 243 + 900);
        chk("t5_lasts", lasts, 1);
        outs = 0;
        send_seq(1, 20, 180, 22, 1'b1, 0, 0, 32, 0);
        drain();
        chk("t5_next_outputs", outs, 900);

        // 6: async reset while stalled
        coef_flat = K_ID;
        rdy_pct = 0;
        send_seq(1, 100, 100, 12, 1'b1, 0, 0, 2, 5);
        repeat (6) cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, idle_acc);
        chk("t6_stalled_valid", out_valid, 1);
        chk("t6_stalled_ready", in_ready, 0);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_px", out_px, 0);
        chk("t6_rst_last", out_last, 0);
        chk("t6_rst_ready", in_ready, 0);
        exp_q.delete();
        exp3_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        rdy_pct = 100;
        push_en = 1'b0;
        outs = 0;
        send_seq(1, 77, 0, 0, 1'b0, 0, 0, 4, 0);
        push_en = 1'b1;
        repeat (10) cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, idle_acc);
        chk("t6_no_sof_outputs", outs, 0);
        first_vld_cyc = -1;
        send_seq(1, 100, 100, 12, 1'b1, 0, 0, 32, 0);
        drain();
        chk("t6_latency", first_vld_cyc - acc_cyc, 4);
        chk("t6_outputs", outs, 900);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
